// File: rtl/fht_loader.sv
// Input-side writer for the FHT core: takes a real-sample stream, scatters it
// bit-reversed across four RAM banks, then kicks fht_control and reports completion.
module fht_loader #(
    parameter int A_BIT = 9,
    parameter int D_BIT = 16,
    parameter int N_LOG = 11
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iLOAD,
    input  logic [D_BIT-1:0] iDATA,
    input  logic             iVALID,
    output logic             oREADY,
    output logic [A_BIT-1:0] oADDR_WR,
    output logic [D_BIT-1:0] oDATA_WR,
    output logic [3:0]       oWE,
    output logic             oSTART,
    input  logic             iFHT_RDY,
    output logic             oBUSY,
    output logic             oDONE
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_KICK,
        S_WAIT,
        S_FIN
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [N_LOG-1:0] k;
    logic [N_LOG-1:0] k_rev;
    logic [1:0]       wait_cnt;
    logic [1:0]       wait_inc;
    logic             accept;
    logic             busy;
    logic [3:0]       we;
    logic [A_BIT-1:0] addr;
    logic [D_BIT-1:0] data;

    always_comb begin
        k_rev = '0;
        for (int unsigned i = 0; i < N_LOG; i++) begin
            k_rev[i] = k[N_LOG-1-i];
        end
    end

    assign accept = iVALID && (state == S_LOAD);

    // wait_cnt holds completed WAIT cycles; wait_inc includes the current one,
    // so RDY is first honoured on the second WAIT cycle.
    assign wait_inc = (wait_cnt == 2'd2) ? 2'd2 : wait_cnt + 2'd1;

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (iLOAD) state_nx = S_LOAD;
            S_LOAD:  if (accept && (k == '1)) state_nx = S_FLUSH;
            S_FLUSH: state_nx = S_KICK;
            S_KICK:  state_nx = S_WAIT;
            S_WAIT:  if ((wait_inc == 2'd2) && iFHT_RDY) state_nx = S_FIN;
            S_FIN:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state    <= S_IDLE;
            k        <= '0;
            wait_cnt <= '0;
            busy     <= 1'b0;
            we       <= '0;
            addr     <= '0;
            data     <= '0;
        end else begin
            state    <= state_nx;
            busy     <= (state_nx != S_IDLE);
            wait_cnt <= (state == S_WAIT) ? wait_inc : 2'd0;
            we       <= '0;
            if (accept) begin
                k    <= k + N_LOG'(1);
                we   <= 4'b0001 << k_rev[N_LOG-1:A_BIT];
                addr <= k_rev[A_BIT-1:0];
                data <= iDATA;
            end
        end
    end

    assign oREADY   = (state == S_LOAD);
    assign oSTART   = (state == S_KICK);
    assign oDONE    = (state == S_FIN);
    assign oBUSY    = busy;
    assign oWE      = we;
    assign oADDR_WR = addr;
    assign oDATA_WR = data;

endmodule

// File: tb/tb_fht_loader.sv
// Self-checking bench for fht_loader: random gaps/data against a bit-reversal
// reference model and a captured image of the four RAM banks.
module tb_fht_loader;

    logic        iCLK = 1'b0;
    logic        iRESET;
    logic        iLOAD;
    logic [15:0] iDATA;
    logic        iVALID;
    logic        oREADY;
    logic [8:0]  oADDR_WR;
    logic [15:0] oDATA_WR;
    logic [3:0]  oWE;
    logic        oSTART;
    logic        iFHT_RDY;
    logic        oBUSY;
    logic        oDONE;

    int n_checks = 0;
    int n_fails  = 0;

    int          hits   [2048];
    logic [15:0] ram    [2048];
    logic [15:0] snap   [2048];
    logic [15:0] sample [2048];

    fht_loader #(.A_BIT(9), .D_BIT(16), .N_LOG(11)) dut (
        .iCLK     (iCLK),
        .iRESET   (iRESET),
        .iLOAD    (iLOAD),
        .iDATA    (iDATA),
        .iVALID   (iVALID),
        .oREADY   (oREADY),
        .oADDR_WR (oADDR_WR),
        .oDATA_WR (oDATA_WR),
        .oWE      (oWE),
        .oSTART   (oSTART),
        .iFHT_RDY (iFHT_RDY),
        .oBUSY    (oBUSY),
        .oDONE    (oDONE)
    );

    always #5 iCLK = ~iCLK;

    function automatic int rev11(input int v);
        int r = 0;
        int x = v;
        for (int i = 0; i < 11; i++) begin
            r = r * 2 + x % 2;
            x = x / 2;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic observe_write();
        for (int b = 0; b < 4; b++) begin
            if (oWE[b] === 1'b1) begin
                hits[b * 512 + int'(oADDR_WR)]++;
                ram[b * 512 + int'(oADDR_WR)] = oDATA_WR;
            end
        end
    endtask

    task automatic clear_hits();
        for (int i = 0; i < 2048; i++) hits[i] = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(oREADY), 32'd0);
        chk({tag, "_we"},    32'(oWE), 32'd0);
        chk({tag, "_start"}, 32'(oSTART), 32'd0);
        chk({tag, "_busy"},  32'(oBUSY), 32'd0);
        chk({tag, "_done"},  32'(oDONE), 32'd0);
        chk({tag, "_addr"},  32'(oADDR_WR), 32'd0);
        chk({tag, "_data"},  32'(oDATA_WR), 32'd0);
    endtask

    // IDLE -> LOAD, with a simultaneous iVALID that must not be taken.
    task automatic start_frame();
        chk("idle_ready", 32'(oREADY), 32'd0);
        iLOAD  = 1'b1;
        iVALID = 1'b1;
        iDATA  = 16'hdead;
        tick();
        iLOAD  = 1'b0;
        iVALID = 1'b0;
        chk("load_busy", 32'(oBUSY), 32'd1);
        chk("load_no_early_we", 32'(oWE), 32'd0);
    endtask

    // Streams samples while in LOAD; stops after 2048 accepts or at abort_at.
    task automatic load_frame(input int gap_pct, input int abort_at, input bit data_is_k);
        int k = 0;
        int guard = 0;
        int r;
        while (k < 2048 && k != abort_at && guard < 20000) begin
            iVALID = ($urandom_range(99) >= gap_pct);
            iDATA  = data_is_k ? 16'(k) : 16'($urandom);
            iLOAD  = ($urandom_range(99) < 2);
            chk("ready_in_load", 32'(oREADY), 32'd1);
            tick();
            if (iVALID) begin
                r = rev11(k);
                sample[k] = iDATA;
                chk("we",   32'(oWE), 32'(1 << (r / 512)));
                chk("addr", 32'(oADDR_WR), 32'(r % 512));
                chk("data", 32'(oDATA_WR), 32'(iDATA));
                if (k == 1) chk("k1_bank2", {oWE, 7'd0, oADDR_WR}, {4'b0100, 16'd0});
                if (k == 2) chk("k2_bank1", {oWE, 7'd0, oADDR_WR}, {4'b0010, 16'd0});
                if (k == 4) chk("k4_bank0", {oWE, 7'd0, oADDR_WR}, {4'b0001, 16'd256});
                k++;
            end else begin
                chk("we_stall", 32'(oWE), 32'd0);
            end
            chk("no_early_start", 32'(oSTART), 32'd0);
            observe_write();
            guard++;
        end
        iVALID = 1'b0;
        iLOAD  = 1'b0;
        chk("load_guard", 32'(guard < 20000), 32'd1);
    endtask

    // From FLUSH through FIN. Offers a 2049th sample in FLUSH.
    task automatic finish_frame(input bit rdy_low);
        chk("flush_ready", 32'(oREADY), 32'd0);
        iVALID = 1'b1;
        iDATA  = 16'hbeef;
        tick();
        iVALID = 1'b0;
        chk("kick_start", 32'(oSTART), 32'd1);
        chk("extra_not_written", 32'(oWE), 32'd0);
        if (!rdy_low) begin
            iFHT_RDY = 1'b1;
            iLOAD    = 1'b1;
            tick();
            iLOAD = 1'b0;
            chk("wait1_start", 32'(oSTART), 32'd0);
            chk("wait1_done", 32'(oDONE), 32'd0);
            tick();
            chk("wait2_done", 32'(oDONE), 32'd0);
            tick();
            chk("fin_done", 32'(oDONE), 32'd1);
            chk("fin_busy", 32'(oBUSY), 32'd1);
        end else begin
            iFHT_RDY = 1'b0;
            for (int i = 0; i < 500; i++) begin
                tick();
                chk("rdy_low_done", 32'(oDONE), 32'd0);
            end
            iFHT_RDY = 1'b1;
            tick();
            chk("rdy_return_done", 32'(oDONE), 32'd1);
        end
        tick();
        chk("post_fin_done", 32'(oDONE), 32'd0);
        chk("post_fin_busy", 32'(oBUSY), 32'd0);
    endtask

    task automatic verify(input string tag, input bit vs_snap);
        int bad = 0;
        int r;
        for (int k = 0; k < 2048; k++) begin
            r = rev11(k);
            if (hits[r] != 1 || ram[r] !== sample[k]) bad++;
            if (vs_snap && ram[r] !== snap[r]) bad++;
        end
        chk(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        iRESET   = 1'b1;
        iLOAD    = 1'b0;
        iDATA    = '0;
        iVALID   = 1'b0;
        iFHT_RDY = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        iRESET = 1'b0;
        tick();

        // Frame 1: back-to-back, data = k, stale RDY held high.
        clear_hits();
        start_frame();
        load_frame(0, -1, 1'b1);
        finish_frame(1'b0);
        verify("frame1_contents", 1'b0);
        for (int i = 0; i < 2048; i++) snap[i] = ram[i];

        // Frame 2: ~30% gaps, same data, slow RDY.
        clear_hits();
        start_frame();
        load_frame(30, -1, 1'b1);
        finish_frame(1'b1);
        verify("frame2_contents_match", 1'b1);

        // Frame 3: aborted by reset after 1000 accepts; iLOAD with reset ignored.
        start_frame();
        load_frame(10, 1000, 1'b0);
        iRESET = 1'b1;
        iLOAD  = 1'b1;
        iVALID = 1'b1;
        tick();
        check_all_zero("abort");
        iRESET = 1'b0;
        iLOAD  = 1'b0;
        iVALID = 1'b0;
        tick();
        chk("abort_idle_busy", 32'(oBUSY), 32'd0);

        // Frame 4: restart from k=0 with random data.
        clear_hits();
        start_frame();
        load_frame(20, -1, 1'b0);
        finish_frame(1'b0);
        verify("frame4_contents", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/fht_loader.md
Name: fht_loader

Overview:
- Input-side writer for the FHT core: accepts a stream of real samples over a valid/ready handshake.
- Writes each sample into the four data RAM banks at the bit-reversed location that fht_control's read addressing expects.
- Once a full frame is stored, pulses fht_control's start input, waits for its ready flag, then reports frame completion.
- Sits between the sample source (ADC/FIFO) and the fht_control plus RAM-bank pair.

Parameters:
- A_BIT, 9: per-bank address width. Each bank holds 512 words.
- D_BIT, 16: sample width, two's complement.
- N_LOG, 11: log2 of frame length. Frame length is 2048 = 4 banks x 512, so N_LOG must equal A_BIT+2.

Ports:
- iCLK  in  1  system clock.
- iRESET  in  1  synchronous reset, active-high.
- iLOAD  in  1  one-cycle request to begin loading a new frame. Honoured only in IDLE.
- iDATA  in  D_BIT  input sample.
- iVALID  in  1  iDATA is valid this cycle.
- oREADY  out  1  loader accepts a sample this cycle.
- oADDR_WR  out  A_BIT  bank write address.
- oDATA_WR  out  D_BIT  bank write data.
- oWE  out  4  one-hot bank write enables, bit b = bank b.
- oSTART  out  1  one-cycle start pulse to fht_control iSTART.
- iFHT_RDY  in  1  fht_control oRDY.
- oBUSY  out  1  high in any state other than IDLE.
- oDONE  out  1  one-cycle pulse when the FHT of the loaded frame has finished.

Behaviour:
- Reset: state IDLE, sample counter k=0, wait counter=0. All outputs 0: oREADY, oWE, oSTART, oBUSY, oDONE, oADDR_WR, oDATA_WR. Reset in any state aborts immediately. Partially written RAM contents are not cleared.
- States and transitions:
  - IDLE: leave when iLOAD=1, go to LOAD.
  - LOAD: oREADY=1 every cycle in this state. Advance to FLUSH after the sample with k=2047 is accepted.
  - FLUSH: one cycle, then KICK.
  - KICK: one cycle, then WAIT.
  - WAIT: go to FIN when wait counter >=2 and iFHT_RDY=1.
  - FIN: one cycle, then IDLE.
- Accept rule: a sample is accepted when iVALID & oREADY. No acceptance outside LOAD. iVALID low in LOAD stalls without penalty; k holds.
- Address mapping for accepted sample k:
  - r = bit-reverse of k over N_LOG bits.
  - bank = r[N_LOG-1 : A_BIT].
  - address = r[A_BIT-1 : 0].
- Write latency: exactly 1 cycle. On the cycle after acceptance, oWE has bit 'bank' set, oADDR_WR = address, oDATA_WR = the sample. In all other cycles oWE=0; oADDR_WR and oDATA_WR hold their last values.
- k is 11 bits and increments on each accept. Acceptance at k=2047 sets k back to 0 and moves LOAD to FLUSH in the same edge. oREADY drops in FLUSH, so at most 2048 samples are accepted per frame.
- FLUSH exists so the last write (issued in FLUSH) completes before fht_control starts reading.
- KICK: oSTART=1 for this cycle only.
- WAIT: the wait counter counts cycles in WAIT and saturates at 2. iFHT_RDY is ignored until the counter reaches 2, which masks the stale RDY from the previous run.
- FIN: oDONE=1 for this cycle only.
- oBUSY is registered: it is 1 from the cycle after iLOAD is sampled in IDLE up to and including FIN.
- iLOAD while not in IDLE is ignored. iLOAD coincident with reset is ignored.
- A simultaneous iVALID and iLOAD in IDLE does not accept the sample, since oREADY=0 in IDLE. The first possible accept is the cycle after.

Test Plan:
- Reset, then iLOAD pulse, then 2048 back-to-back samples with value = k -> first write appears 1 cycle after the first accept. k=1 goes to bank 2, addr 0. k=2 goes to bank 1, addr 0. k=4 goes to bank 0, addr 256. Each of the 2048 (bank, addr) pairs is written exactly once. oSTART pulses exactly 2 cycles after the last accept.
- Random iVALID gaps (~30% low) during LOAD -> identical bank contents to the back-to-back case. k never advances on iVALID=0.
- iFHT_RDY held 1 throughout -> oDONE asserts 3 cycles after oSTART (WAIT lasts 2 cycles, then FIN). Drive RDY low for 500 cycles after oSTART -> oDONE exactly 1 cycle after RDY returns high.
- iLOAD pulsed during LOAD and during WAIT -> no effect. After oDONE, a new iLOAD starts a fresh frame at k=0.
- iRESET asserted after 1000 accepted samples -> next cycle all outputs 0, state IDLE. A subsequent iLOAD restarts at k=0, and oSTART fires only after 2048 further accepts.
- 2049 samples offered continuously -> exactly 2048 accepted, and oREADY=0 on the cycle the 2049th is presented.
